// File: rtl/ma_mem_arbiter.sv
// Round-robin arbiter sequencing the MA register and single-port memory for fetch (F) and data (D) requesters.
// Latency: request sampled in IDLE, MA loaded the next cycle, done pulses MEM_LAT+2 cycles after sampling.
// Backpressure: requesters hold req until their done pulse; one access per MEM_LAT+3 cycles at most.
module ma_mem_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 12,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          ma_en,
    output logic [AW-1:0] ma_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
    typedef enum logic {OWN_F, OWN_D} owner_t;

    // WAIT runs from CNT_INIT down to zero inclusive, i.e. MEM_LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state, state_nxt;
    owner_t        owner, owner_nxt;
    owner_t        ptr, ptr_nxt;
    owner_t        pick;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          we_q, we_nxt;
    logic [DW-1:0] wdata_q, wdata_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [DW-1:0] rdata_nxt;

    // State, latched request and read-data registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_F;
            ptr     <= OWN_F;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
            cnt     <= cnt_nxt;
            rdata   <= rdata_nxt;
        end
    end

    // Arbitration, latency timing and memory-side outputs.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        addr_nxt  = addr_q;
        we_nxt    = we_q;
        wdata_nxt = wdata_q;
        cnt_nxt   = cnt;
        rdata_nxt = rdata;
        f_done    = 1'b0;
        d_done    = 1'b0;
        ma_en     = 1'b0;
        ma_addr   = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = (state != IDLE);
        // Pointer only matters on a tie; a lone requester always wins.
        if (f_req && d_req) begin
            pick = ptr;
        end else if (d_req) begin
            pick = OWN_D;
        end else begin
            pick = OWN_F;
        end

        case (state)
            IDLE: begin
                if (f_req || d_req) begin
                    owner_nxt = pick;
                    if (pick == OWN_D) begin
                        addr_nxt  = d_addr;
                        we_nxt    = d_we;
                        wdata_nxt = d_wdata;
                    end else begin
                        addr_nxt  = f_addr;
                        we_nxt    = 1'b0;
                        wdata_nxt = '0;
                    end
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ma_en     = 1'b1;
                ma_addr   = addr_q;
                cnt_nxt   = CNT_INIT;
                state_nxt = WAIT;
            end
            WAIT: begin
                ma_addr = addr_q;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end
                if (cnt == 4'd0) begin
                    if (!we_q) begin
                        rdata_nxt = mem_rdata;
                    end
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                ma_addr   = addr_q;
                f_done    = (owner == OWN_F);
                d_done    = (owner == OWN_D);
                ptr_nxt   = (owner == OWN_F) ? OWN_D : OWN_F;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        f_gnt = busy && (owner == OWN_F);
        d_gnt = busy && (owner == OWN_D);
    end

endmodule

// File: tb/tb_ma_mem_arbiter.sv
// Self-checking bench for ma_mem_arbiter: scoreboard of expected completions checked by a done monitor.
// Latency: expected done cycles are derived from the arbitration order and MEM_LAT.
// Backpressure: requesters hold req until done, then drop it on the following edge.
module tb_ma_mem_arbiter;

    localparam int L = 2;

    typedef struct {
        bit          who;      // 0 = fetch, 1 = data
        bit          we;
        logic [11:0] addr;
        logic [11:0] wdata;
        logic [11:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        int          cyc;
    } e1_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we;
    logic [11:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_done, d_gnt, d_done, ma_en, mem_we, busy;
    logic [11:0] rdata, ma_addr, mem_wdata, mem_rdata;

    logic        f_req1;
    logic [11:0] f_addr1;
    logic        f_gnt1, f_done1, d_gnt1, d_done1, ma_en1, mem_we1, busy1;
    logic [11:0] rdata1, ma_addr1, mem_wdata1, mem_rdata1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int we_cnt = 0;

    exp_t        sbq[$];
    e1_t         q1[$];
    logic [11:0] ref_mem [int];
    bit          last_srv = 1'b1;   // reset pointer favours fetch
    logic [11:0] last_rd  = 12'h000;

    // Behavioural MA register plus memory for each instance.
    logic [11:0] mem [0:4095];
    bit          wr_ok [0:4095];
    logic [11:0] ma_reg = 12'h000;
    logic [11:0] ma_reg1 = 12'h000;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h000, pl_dat = 12'h000;

    ma_mem_arbiter #(.AW(12), .DW(12), .MEM_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
        .ma_en(ma_en), .ma_addr(ma_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    ma_mem_arbiter #(.AW(12), .DW(12), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_done(f_done1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(12'h000), .d_wdata(12'h000),
        .d_gnt(d_gnt1), .d_done(d_done1), .rdata(rdata1),
        .ma_en(ma_en1), .ma_addr(ma_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ma_en) ma_reg <= ma_addr;
        if (ma_en1) ma_reg1 <= ma_addr1;
        if (mem_we) begin
            mem[ma_reg]   <= mem_wdata;
            wr_ok[ma_reg] <= 1'b1;
        end
        if (pl_en) begin
            mem[pl_addr]   <= pl_dat;
            wr_ok[pl_addr] <= 1'b1;
        end
    end

    assign mem_rdata  = wr_ok[ma_reg] ? mem[ma_reg] : (ma_reg ^ 12'hC3A);
    assign mem_rdata1 = ma_reg1 ^ 12'h5A5;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] ref_rd(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a ^ 12'hC3A;
    endfunction

    // Reference model: accesses complete in service order against a flat memory.
    task automatic model_push(input bit who, input bit we, input logic [11:0] a,
                              input logic [11:0] wd, input int c);
        exp_t e;
        e.who   = who;
        e.we    = we;
        e.addr  = a;
        e.wdata = we ? wd : 12'h000;
        e.cyc   = c;
        if (we) begin
            ref_mem[int'(a)] = wd;
            e.rdata = last_rd;
        end else begin
            e.rdata = ref_rd(a);
            last_rd = e.rdata;
        end
        last_srv = who;
        sbq.push_back(e);
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
        ref_mem[int'(a)] = d;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) chk_eq("idle_timeout", int'(busy), 0);
    endtask

    // One arbitration round: assert the chosen requests together and serve until all done.
    task automatic round(input bit fr, input bit dr, input logic [11:0] fa, input bit dwe,
                         input logic [11:0] da, input logic [11:0] dwd, input bit wd);
        int c0, n, t;
        bit first, fdn, ddn;
        wait_idle();
        c0 = cyc;
        if (fr && dr) first = (last_srv == 1'b0);
        else          first = dr;
        if (first) model_push(1'b1, dwe, da, dwd, c0 + 2 + L);
        else       model_push(1'b0, 1'b0, fa, 12'h000, c0 + 2 + L);
        if (fr && dr) begin
            if (first) model_push(1'b0, 1'b0, fa, 12'h000, c0 + 5 + 2 * L);
            else        model_push(1'b1, dwe, da, dwd, c0 + 5 + 2 * L);
        end
        f_addr = fa; d_we = dwe; d_addr = da; d_wdata = dwd;
        f_req = fr; d_req = dr;
        n = int'(fr) + int'(dr);
        t = 0;
        while (n > 0 && t < 60) begin
            @(negedge clk);
            fdn = f_done;
            ddn = d_done;
            @(posedge clk); #1;
            t++;
            if (fdn) begin f_req = 1'b0; n--; end
            if (ddn) begin d_req = 1'b0; n--; end
            if (wd && f_gnt && !ma_en) begin
                f_req  = 1'b0;
                f_addr = 12'($urandom);
            end
            if (wd && d_gnt && !ma_en) begin
                d_req   = 1'b0;
                d_addr  = 12'($urandom);
                d_wdata = 12'($urandom);
                d_we    = 1'($urandom);
            end
        end
        if (n > 0) begin
            chk_eq("round_timeout", n, 0);
            f_req = 1'b0;
            d_req = 1'b0;
        end else begin
            chk_eq("busy_after_done", int'(busy), 0);
        end
    endtask

    // Scoreboard monitor for the MEM_LAT=2 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk_eq("gnt_excl", int'(f_gnt & d_gnt), 0);
            chk_eq("done_excl", int'(f_done & d_done), 0);
            if (ma_en) begin
                we_cnt = 0;
                if (sbq.size() == 0) chk_eq("unexpected_load", int'(ma_en), 0);
            end
            if ((f_gnt || d_gnt) && !f_done && !d_done && sbq.size() > 0) begin
                chk_eq("ma_addr", int'(ma_addr), int'(sbq[0].addr));
                chk_eq("gnt_owner", int'(d_gnt), int'(sbq[0].who));
            end
            if (mem_we) begin
                if (sbq.size() > 0 && sbq[0].we && mem_wdata == sbq[0].wdata &&
                    ma_addr == sbq[0].addr)
                    we_cnt++;
                else
                    we_cnt += 100;
            end
            if (f_done || d_done) begin
                if (sbq.size() == 0) begin
                    chk_eq("unexpected_done", int'({f_done, d_done}), 0);
                end else begin
                    e = sbq.pop_front();
                    chk_eq("done_who", int'(d_done), int'(e.who));
                    chk_eq("done_cycle", cyc, e.cyc);
                    chk_eq("rdata", int'(rdata), int'(e.rdata));
                    chk_eq("mem_we_cycles", we_cnt, e.we ? L : 0);
                end
            end
        end
    end

    // Scoreboard monitor for the MEM_LAT=1 fetch stream.
    always @(negedge clk) begin
        if (rst_n) begin
            e1_t e;
            chk_eq("l1_side", int'({d_gnt1, d_done1, mem_we1, mem_wdata1}), 0);
            if (f_done1) begin
                if (q1.size() == 0) begin
                    chk_eq("l1_unexpected_done", int'(f_done1), 0);
                end else begin
                    e = q1.pop_front();
                    chk_eq("l1_done_cycle", cyc, e.cyc);
                    chk_eq("l1_rdata", int'(rdata1), int'(e.addr ^ 12'h5A5));
                    chk_eq("l1_gnt", int'(f_gnt1), 1);
                end
            end
        end
    end

    initial begin
        int c0, p;
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = 12'h000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 12'h000; d_wdata = 12'h000;
        f_req1 = 1'b0; f_addr1 = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_ctl", int'({f_gnt, d_gnt, f_done, d_done, ma_en, mem_we, busy}), 0);
        chk_eq("reset_bus", int'({ma_addr, mem_wdata}), 0);
        chk_eq("reset_rdata", int'(rdata), 0);
        rst_n = 1'b1;

        // Simultaneous requests right after reset, twice: F, D, F, D.
        round(1'b1, 1'b1, 12'h0A1, 1'b0, 12'h040, 12'h000, 1'b0);
        round(1'b1, 1'b1, 12'h0A2, 1'b0, 12'h041, 12'h000, 1'b0);
        // Single fetch of a known word.
        preload(12'h123, 12'hABC);
        round(1'b1, 1'b0, 12'h123, 1'b0, 12'h000, 12'h000, 1'b0);
        // Data write; rdata must hold the previous read.
        round(1'b0, 1'b1, 12'h000, 1'b1, 12'hFFF, 12'h555, 1'b0);
        // Read-back of the written word.
        round(1'b0, 1'b1, 12'h000, 1'b0, 12'hFFF, 12'h000, 1'b0);
        // Request withdrawn and inputs scrambled mid-access.
        preload(12'h200, 12'h6D1);
        round(1'b0, 1'b1, 12'h000, 1'b0, 12'h200, 12'h000, 1'b1);

        // Random mix over a small address window so writes get read back.
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(1, 3));
            round((p & 1) != 0, (p & 2) != 0, 12'($urandom_range(0, 15)), 1'($urandom),
                  12'($urandom_range(0, 15)), 12'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset in the first WAIT cycle of a fetch.
        wait_idle();
        sbq.push_back('{who: 1'b0, we: 1'b0, addr: 12'h3A5, wdata: 12'h000,
                       rdata: 12'h000, cyc: cyc + 2 + L});
        f_addr = 12'h3A5;
        f_req  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_eq("pre_reset_gnt", int'(f_gnt), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_ctl", int'({f_gnt, d_gnt, f_done, d_done, ma_en, mem_we, busy}), 0);
        chk_eq("midrst_bus", int'({ma_addr, mem_wdata}), 0);
        chk_eq("midrst_rdata", int'(rdata), 0);
        sbq.delete();
        f_req    = 1'b0;
        last_srv = 1'b1;
        last_rd  = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        round(1'b1, 1'b0, 12'h3A5, 1'b0, 12'h000, 12'h000, 1'b0);
        round(1'b1, 1'b1, 12'h010, 1'b0, 12'h011, 12'h000, 1'b0);

        // MEM_LAT=1 instance: continuous fetch stream, one done every 4 cycles.
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            while (cyc < c0 + 4 * k) begin
                @(posedge clk); #1;
            end
            f_addr1 = 12'($urandom);
            q1.push_back('{addr: f_addr1, cyc: c0 + 4 * k + 3});
            f_req1 = 1'b1;
        end
        while (cyc < c0 + 24) begin
            @(posedge clk); #1;
        end
        f_req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("l1_busy_end", int'(busy1), 0);
        chk_eq("l1_queue_left", q1.size(), 0);
        chk_eq("queue_left", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ma_mem_arbiter.md
Name: ma_mem_arbiter

Overview:
- Sequences the 12-bit memory address register and the single-port main memory for two requesters:
  - instruction fetch (F);
  - operand data access (D).
- Arbitrates between them with round-robin priority and drives the MA load enable and address.
- Times the fixed memory latency, then returns read data or commits write data with a one-cycle done pulse.
- Sits between the control unit and the MA register/memory pair.

Parameters:
AW, 12, address width (MA width)
DW, 12, memory word width
MEM_LAT, 2, cycles from MA load to valid mem_rdata (legal 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
f_req  input  1  fetch request; held until f_done
f_addr  input  AW  fetch address
f_gnt  output  1  fetch granted; high from LOAD through DONE
f_done  output  1  one-cycle pulse; rdata valid for fetch
d_req  input  1  data request; held until d_done
d_we  input  1  1 = write, 0 = read
d_addr  input  AW  data address
d_wdata  input  DW  data write value
d_gnt  output  1  data granted; high from LOAD through DONE
d_done  output  1  one-cycle pulse; rdata valid (read) or write committed
rdata  output  DW  registered read data, shared by both requesters
ma_en  output  1  load enable to MA register
ma_addr  output  AW  address presented to MA
mem_we  output  1  memory write strobe
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
busy  output  1  high in any state other than IDLE

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is asynchronous and active-low on rst_n.

Reset (rst_n=0, any time, including mid-transaction):
- state=IDLE; all outputs 0; rdata=0; wait counter=0.
- Priority pointer selects F.
- Any in-flight transaction is dropped with no done pulse.

States and transitions:
- IDLE:
  - Samples f_req/d_req.
  - Only one request high -> grant it.
  - Both high -> grant per pointer.
  - On grant: latch addr, we (0 for F) and wdata into internal regs; set owner; go to LOAD.
  - No request -> stay in IDLE.
- LOAD (1 cycle):
  - ma_en=1; ma_addr = latched addr.
  - Owner's gnt=1.
  - Counter loaded with MEM_LAT-1; go to WAIT.
- WAIT (MEM_LAT cycles):
  - ma_en=0; ma_addr holds the latched addr.
  - If latched we=1: mem_we=1 and mem_wdata = latched wdata for every WAIT cycle.
  - Counter decrements each cycle.
  - At counter=0: capture mem_rdata into rdata (reads only; writes leave rdata unchanged); go to DONE.
- DONE (1 cycle):
  - Owner's done=1; mem_we=0.
  - Pointer flips to the non-owner; go to IDLE.

Timing:
- Latency: req sampled in IDLE at cycle 0 -> ma_en in cycle 1 -> done in cycle 2+MEM_LAT.
- The requester must drop req on the edge where it observes done.
- The IDLE cycle after DONE is mandatory, giving a throughput of one access per MEM_LAT+3 cycles.

Boundary conditions:
- Req deasserted while granted: ignored; the transaction completes and done still pulses.
- Requester inputs (addr, we, wdata) changing after grant: ignored (latched values are used).
- Only one requester active: it is granted every time, regardless of the pointer.
- f_gnt and d_gnt are never high together; f_done and d_done are never high together.
- MEM_LAT=1: WAIT lasts exactly one cycle.

Test Plan:
- Single fetch, MEM_LAT=2, memory holds 0xABC at 0x123: f_req=1, f_addr=0x123 at cycle 0 -> ma_en=1 and ma_addr=0x123 in cycle 1; f_done=1 and rdata=0xABC in cycle 4; busy low again in cycle 5.
- Simultaneous requests right after reset: f_req and d_req both held high, d_addr=0x040 -> F served first (f_done cycle 4), D granted from the next IDLE (d_done cycle 9); repeated requests continue to alternate F, D, F.
- Data write: d_we=1, d_addr=0xFFF, d_wdata=0x555 -> mem_we=1 with mem_wdata=0x555 for exactly 2 cycles (cycles 2-3); d_done in cycle 4; rdata unchanged.
- Reset mid-WAIT: assert rst_n=0 in cycle 2 of a fetch -> all outputs 0 immediately; no f_done; after release a new fetch completes normally, F-first.
- Request withdrawal and input change: drop d_req and change d_addr to 0x000 in cycle 2 of a read of 0x200 -> ma_addr stays 0x200, d_done still pulses in cycle 4 with data from 0x200.
- MEM_LAT=1 back-to-back fetch stream: f_req held continuously -> done pulses every 4 cycles; d_gnt never asserts.
